logic_unit_pipe: RTL and testbench
==================================

# logic_unit_pipe

Parametrised, pipelined multi-function logic unit: the registered, handshaked successor of the single-bit AND/NAND selector.
- Applies one of eight bitwise operations to two WIDTH-bit operands.
- Optionally replaces operand b with an internal accumulator holding the last result.
- Delivers the result through a two-stage valid/ready pipeline.
- Sits between an operand source and any consumer that may apply backpressure.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥1)

Ports:
- clk      input   1      single clock; all state updates on rising edge
- reset    input   1      synchronous, active-high reset
- in_valid input   1      operand beat offered
- in_ready output  1      unit can accept a beat this cycle
- a        input   WIDTH  operand a
- b        input   WIDTH  operand b (ignored when acc_mode=1)
- op       input   3      operation select (see Operation)
- acc_mode input   1      1: use accumulator in place of b
- out_valid output 1      result beat present
- out_ready input  1      consumer takes result this cycle
- result   output  WIDTH  registered result
- zero     output  1      result == 0
- ones     output  1      result == all ones

## Operation
- Operation encoding:
  - 0 AND
  - 1 NAND
  - 2 OR
  - 3 NOR
  - 4 XOR
  - 5 XNOR
  - 6 NOT a (b ignored)
  - 7 PASS a (b ignored)
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage 1 (S1): registers a, b, op, acc_mode plus valid bit s1_v on input transfer.
- Stage 2 (S2):
  - Computes result from S1 contents: operand b_eff = acc_mode ? acc : b.
  - Registers result, zero, ones and out_valid.
- Accumulator acc (WIDTH bits):
  - Loads the computed result whenever S2 loads, regardless of acc_mode.
  - Back-to-back acc_mode beats therefore chain correctly: each sees the previous beat's result.
- Advance conditions:
  - s2_adv = s1_v && (!out_valid || out_ready).
  - in_ready = !reset && (!s1_v || s2_adv). Combinational.
  - No skid buffer: at most 2 beats in flight.
- Register updates:
  - S1 loads on input transfer. Otherwise s1_v clears on s2_adv.
  - S2 loads on s2_adv. Otherwise out_valid clears on output transfer.
- zero/ones are registered with result; they are not recomputed from result combinationally.
- Results never reorder, drop or duplicate.

## Timing
- Reset (synchronous, takes effect on the edge where reset=1):
  - s1_v=0, out_valid=0, result=0, acc=0, zero=1, ones=0.
  - in_ready=0 while reset is high.
- Reset mid-operation: all in-flight beats are discarded. No out_valid pulse follows reset deassertion until a new input transfer occurs.
- Latency: input transfer at edge N gives out_valid=1 after edge N+1, with result valid from that point. That is 2 cycles from presenting a beat to seeing it on result.
- Throughput: 1 beat/cycle with out_ready held high.
- Backpressure:
  - With out_ready=0, S2 holds result/flags stable while out_valid=1.
  - S1 fills, then in_ready drops the cycle after the second beat is accepted.
- Simultaneous events:
  - Output transfer and s2_adv in the same cycle: S2 loads the new beat, out_valid stays 1.
  - Input transfer and s2_adv in the same cycle: S1 loads, s1_v stays 1.
- Acc update timing: acc changes only on s2_adv. A stalled S2 does not alter acc.
- result, zero and ones are undefined-by-contract when out_valid=0. The values listed for reset are nonetheless required.

## Test plan
1. Reset, then a=0xF0, b=0x3C through ops 0..7, out_ready=1. Required, in order, each 2 cycles after its input:
   - 0x30, 0xCF, 0xFC, 0x03, 0xCC, 0x33, 0x0F, 0xF0.
   - zero=0 and ones=0 throughout.
2. Accumulator chain after reset, acc_mode=1, back-to-back beats:
   - OR a=0x01 gives 0x01.
   - OR a=0x80 gives 0x81.
   - XOR a=0x81 gives 0x00 with zero=1.
   - NOR a=0x00 gives 0xFF with ones=1.
3. Backpressure:
   - out_ready=0, offer 3 beats AND a=0xFF b=0x11/0x22/0x33.
   - in_ready falls after 2 accepted; result holds 0x11.
   - Raise out_ready: outputs 0x11, 0x22, 0x33 on consecutive cycles, third accepted when space opens.
4. Full-rate streaming: 16 random beats with in_valid and out_ready held 1. Required: 16 results on consecutive cycles, matching the reference model, no gaps after first output.
5. Reset mid-operation:
   - Two beats in flight, assert reset for 1 cycle.
   - Outputs return to their reset values and acc=0.
   - A subsequent acc_mode OR a=0x05 returns 0x05.
6. Random out_ready toggling over 200 beats with mixed acc_mode. Scoreboard checks order, values, flags and acc chaining.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready bitwise logic unit (8 operations) with an
// accumulator that can stand in for operand b, holding the most recent result.
module logic_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ones
);

    function automatic logic [WIDTH-1:0] logic_op(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        case (sel)
            3'd0:    r = x & y;
            3'd1:    r = ~(x & y);
            3'd2:    r = x | y;
            3'd3:    r = ~(x | y);
            3'd4:    r = x ^ y;
            3'd5:    r = ~(x ^ y);
            3'd6:    r = ~x;
            default: r = x;
        endcase
        return r;
    endfunction

    logic             vld_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic [2:0]       op_p1;
    logic             acc_mode_p1;

    logic             vld_p2;
    logic [WIDTH-1:0] result_p2;
    logic             zero_p2;
    logic             ones_p2;
    logic [WIDTH-1:0] acc;

    logic             in_xfer;
    logic             s2_adv;
    logic [WIDTH-1:0] b_eff_p1;
    logic [WIDTH-1:0] res_p1;

    assign s2_adv   = vld_p1 && (!vld_p2 || out_ready);
    assign in_ready = !reset && (!vld_p1 || s2_adv);
    assign in_xfer  = in_valid && in_ready;

    // ---- stage 0 -> 1: operand capture (data registers need no reset) ----
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            a_p1        <= a;
            b_p1        <= b;
            op_p1       <= op;
            acc_mode_p1 <= acc_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (in_xfer) begin
            vld_p1 <= 1'b1;
        end else if (s2_adv) begin
            vld_p1 <= 1'b0;
        end
    end

    // ---- stage 1 -> 2: compute, register result/flags, update accumulator ----
    assign b_eff_p1 = acc_mode_p1 ? acc : b_p1;
    assign res_p1   = logic_op(op_p1, a_p1, b_eff_p1);

    // Result, flags and acc carry defined reset values, so they share the control reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            zero_p2   <= 1'b1;
            ones_p2   <= 1'b0;
            acc       <= '0;
        end else if (s2_adv) begin
            vld_p2    <= 1'b1;
            result_p2 <= res_p1;
            zero_p2   <= ~|res_p1;
            ones_p2   <= &res_p1;
            acc       <= res_p1;
        end else if (out_ready) begin
            vld_p2    <= 1'b0;
        end
    end

    assign out_valid = vld_p2;
    assign result    = result_p2;
    assign zero      = zero_p2;
    assign ones      = ones_p2;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and scoreboard tests for logic_unit_pipe: op sweep, accumulator chaining,
// backpressure, full-rate streaming, mid-operation reset and random stalls.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;
    logic       acc_mode = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic       zero;
    logic       ones;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc_mode(acc_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .ones(ones)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_op(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
        case (s)
            3'd0: return x & y;
            3'd1: return ~(x & y);
            3'd2: return x | y;
            3'd3: return ~(x | y);
            3'd4: return x ^ y;
            3'd5: return ~(x ^ y);
            3'd6: return ~x;
            default: return x;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        do_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 8'h00 || zero !== 1'b1 || ones !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got v=%b r=%h z=%b o=%b rdy=%b exp v=0 r=00 z=1 o=0 rdy=1",
                     out_valid, result, zero, ones, in_ready);
        end
    endtask

    task automatic test_op_sweep();
        logic [7:0] exp_r [8];
        int got = 0;
        exp_r = '{8'h30, 8'hCF, 8'hFC, 8'h03, 8'hCC, 8'h33, 8'h0F, 8'hF0};
        do_reset();
        out_ready = 1'b1; acc_mode = 1'b0; a = 8'hF0; b = 8'h3C;
        for (int w = 0; w < 20 && got < 8; w++) begin
            in_valid = (w < 8);
            op = w[2:0];
            #1;
            if (out_valid) begin
                checks++;
                if (result !== exp_r[got] || zero !== 1'b0 || ones !== 1'b0 || w != got + 2) begin
                    failures++;
                    $display("FAIL op_sweep[%0d] got r=%h z=%b o=%b win=%0d exp r=%h z=0 o=0 win=%0d",
                             got, result, zero, ones, w, exp_r[got], got + 2);
                end
                got++;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (got != 8) begin
            failures++; $display("FAIL op_sweep_count got=%0d exp=8", got);
        end
    endtask

    task automatic test_acc_chain();
        logic [7:0] av [4];
        logic [2:0] ov [4];
        logic [7:0] er [4];
        logic       ez [4];
        logic       eo [4];
        int got = 0;
        av = '{8'h01, 8'h80, 8'h81, 8'h00};
        ov = '{3'd2, 3'd2, 3'd4, 3'd3};
        er = '{8'h01, 8'h81, 8'h00, 8'hFF};
        ez = '{1'b0, 1'b0, 1'b1, 1'b0};
        eo = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        out_ready = 1'b1; acc_mode = 1'b1; b = 8'hAA;
        for (int w = 0; w < 12 && got < 4; w++) begin
            in_valid = (w < 4);
            if (w < 4) begin
                a = av[w]; op = ov[w];
            end
            #1;
            if (out_valid) begin
                checks++;
                if (result !== er[got] || zero !== ez[got] || ones !== eo[got]) begin
                    failures++;
                    $display("FAIL acc_chain[%0d] got r=%h z=%b o=%b exp r=%h z=%b o=%b",
                             got, result, zero, ones, er[got], ez[got], eo[got]);
                end
                got++;
            end
            next_cycle();
        end
        in_valid = 1'b0; acc_mode = 1'b0;
        checks++;
        if (got != 4) begin
            failures++; $display("FAIL acc_chain_count got=%0d exp=4", got);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        acc_mode = 1'b0; op = 3'd0; a = 8'hFF;
        out_ready = 1'b0; in_valid = 1'b1; b = 8'h11;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept1 got=%b exp=1", in_ready); end
        next_cycle();
        b = 8'h22;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept2 got=%b exp=1", in_ready); end
        next_cycle();
        b = 8'h33;
        for (int w = 0; w < 2; w++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 8'h11 || zero !== 1'b0 || ones !== 1'b0) begin
                failures++;
                $display("FAIL bp_stall[%0d] got rdy=%b v=%b r=%h z=%b o=%b exp rdy=0 v=1 r=11 z=0 o=0",
                         w, in_ready, out_valid, result, zero, ones);
            end
            next_cycle();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || result !== 8'h11) begin
            failures++;
            $display("FAIL bp_release got rdy=%b v=%b r=%h exp rdy=1 v=1 r=11", in_ready, out_valid, result);
        end
        next_cycle();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h22) begin
            failures++; $display("FAIL bp_out2 got v=%b r=%h exp v=1 r=22", out_valid, result);
        end
        next_cycle();
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h33) begin
            failures++; $display("FAIL bp_out3 got v=%b r=%h exp v=1 r=33", out_valid, result);
        end
        next_cycle();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got v=%b exp v=0", out_valid); end
    endtask

    task automatic test_full_rate();
        logic [7:0] macc = 8'h00;
        logic [7:0] e;
        int sent = 0, recv = 0, first = -1;
        do_reset();
        exp_q.delete();
        out_ready = 1'b1;
        for (int w = 0; w < 40 && recv < 16; w++) begin
            in_valid = (sent < 16);
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom); acc_mode = 1'($urandom);
            #1;
            if (out_valid) begin
                if (first < 0) first = w;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                checks++;
                if (result !== e || zero !== (e == 8'h00) || ones !== (e == 8'hFF) || w != first + recv) begin
                    failures++;
                    $display("FAIL stream[%0d] got r=%h z=%b o=%b win=%0d exp r=%h win=%0d",
                             recv, result, zero, ones, w, e, first + recv);
                end
                recv++;
            end
            if (in_valid) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", sent, in_ready);
                end else begin
                    e = ref_op(op, a, acc_mode ? macc : b);
                    macc = e;
                    exp_q.push_back(e);
                    sent++;
                end
            end
            next_cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (recv != 16 || first != 2) begin
            failures++; $display("FAIL stream_count got n=%0d first=%0d exp n=16 first=2", recv, first);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        acc_mode = 1'b0; op = 3'd7; b = 8'h00;
        out_ready = 1'b0; in_valid = 1'b1;
        a = 8'h5A; next_cycle();
        a = 8'hA5; next_cycle();
        in_valid = 1'b0;
        reset = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_in_ready got=%b exp=0", in_ready); end
        next_cycle();
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 8'h00 || zero !== 1'b1 || ones !== 1'b0 || dut.acc !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_state got v=%b r=%h z=%b o=%b acc=%h exp v=0 r=00 z=1 o=0 acc=00",
                     out_valid, result, zero, ones, dut.acc);
        end
        for (int w = 0; w < 3; w++) begin
            next_cycle();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_ghost[%0d] got v=%b exp v=0", w, out_valid); end
        end
        acc_mode = 1'b1; op = 3'd2; a = 8'h05; b = 8'hF0; in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h05) begin
            failures++; $display("FAIL mid_reset_acc got v=%b r=%h exp v=1 r=05", out_valid, result);
        end
        acc_mode = 1'b0;
        next_cycle();
    endtask

    task automatic test_random_stall();
        logic [7:0] macc = 8'h00;
        logic [7:0] e;
        int sent = 0, recv = 0;
        do_reset();
        exp_q.delete();
        for (int w = 0; w < 3000 && recv < 200; w++) begin
            in_valid = (sent < 200) && ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom);
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom); acc_mode = 1'($urandom);
            #1;
            if (out_valid) begin
                e = (exp_q.size() > 0) ? exp_q[0] : 8'hxx;
                checks++;
                if (result !== e || zero !== (e == 8'h00) || ones !== (e == 8'hFF)) begin
                    failures++;
                    $display("FAIL random[%0d] got r=%h z=%b o=%b exp r=%h", recv, result, zero, ones, e);
                end
                if (out_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    recv++;
                end
            end
            if (in_valid && in_ready) begin
                e = ref_op(op, a, acc_mode ? macc : b);
                macc = e;
                exp_q.push_back(e);
                sent++;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (recv != 200 || exp_q.size() != 0) begin
            failures++; $display("FAIL random_count got n=%0d left=%0d exp n=200 left=0", recv, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_op_sweep();
        test_acc_chain();
        test_backpressure();
        test_full_rate();
        test_reset_mid();
        test_random_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
